// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch slice.
//   fetch_state_t : fetch FSM state encoding
//   INSTR_BYTES   : PC increment per instruction
//   J_TARGET_W    : width of the j-type target field
//   IMM_W         : width of the i-type immediate field
package mips_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        ERROR
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned J_TARGET_W  = 26;
    localparam int unsigned IMM_W       = 16;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the instruction being accepted.
// Ports:
//   pc_plus4 (in, 32) : address of the sequentially following instruction
//   instr    (in, 32) : accepted instruction word
//   branch   (in, 1)  : instruction is a conditional branch
//   zero     (in, 1)  : ALU zero flag for that branch
//   jump     (in, 1)  : instruction is j-type (takes priority over branch)
//   next_pc  (out, 32): address of the next instruction to fetch
module next_pc_calc
    import mips_pkg::*;
(
    input  logic [31:0] pc_plus4,
    input  logic [31:0] instr,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic [31:0] next_pc
);

    logic [31:0] jump_target;
    logic [31:0] branch_offset;

    // Jump keeps the upper nibble of the following instruction's region.
    assign jump_target = {pc_plus4[31:28], instr[J_TARGET_W-1:0], 2'b00};

    // Sign-extended word offset converted to bytes.
    assign branch_offset = {{(32 - IMM_W - 2){instr[IMM_W-1]}}, instr[IMM_W-1:0], 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = jump_target;
        end else if (branch && zero) begin
            next_pc = pc_plus4 + branch_offset;
        end
    end

    // Opcode bits are not needed for target computation.
    logic unused_opcode;
    assign unused_opcode = ^instr[31:J_TARGET_W];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction memory,
// holds the fetched word until downstream accepts it, then steps the PC.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   imem_req/imem_addr  : read request and word address to instruction memory
//   imem_rdata/valid    : returned instruction word and its valid strobe
//   instr/instr_valid   : held instruction presented to decode
//   instr_ready         : downstream accepts instr this cycle
//   pc/pc_plus4         : address of the held/fetching instruction and pc + 4
//   branch/zero/jump    : control resolution for the accepted instruction
//   fetch_err           : sticky memory-timeout flag, cleared only by rst
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        branch,
    input  logic        zero,
    input  logic        jump,
    output logic        fetch_err
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [31:0]  next_pc;

    assign pc_plus4 = pc_q + 32'(INSTR_BYTES);

    next_pc_calc u_next_pc_calc (
        .pc_plus4 (pc_plus4),
        .instr    (instr_q),
        .branch   (branch),
        .zero     (zero),
        .jump     (jump),
        .next_pc  (next_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            HOLD: begin
                // No timeout here: downstream may stall indefinitely.
                if (instr_ready) begin
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
            ERROR: begin
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        fetch_err;

    always #5 clk = ~clk;

    // Memory model: zero-wait when enabled; spur_valid injects stray strobes.
    logic [31:0] mem [0:255];
    logic        mem_en;
    logic        spur_valid;
    logic        zero_ctl;
    logic        jb_both;

    assign imem_valid = (mem_en & imem_req) | spur_valid;
    assign imem_rdata = spur_valid ? 32'hDEAD_BEEF : mem[imem_addr[9:2]];

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .fetch_err   (fetch_err)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic [31:0] req_q[$];
    exp_t        acc_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    // Advance one cycle; act as the downstream decoder for branch/jump.
    task automatic step();
        logic [5:0] op;
        @(posedge clk);
        #1;
        cyc++;
        op     = instr[31:26];
        jump   = instr_valid && (op == 6'h02);
        branch = instr_valid && ((op == 6'h04) || ((op == 6'h02) && jb_both));
        zero   = zero_ctl;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 256; i++) mem[i] = {6'h08, 26'(i)};
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        mem_en      = 1'b0;
        spur_valid  = 1'b0;
        instr_ready = 1'b0;
        zero_ctl    = 1'b0;
        jb_both     = 1'b0;
        req_q.delete();
        acc_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        mem_en      = 1'b0;
        spur_valid  = 1'b0;
        instr_ready = 1'b0;
        zero_ctl    = 1'b0;
        jb_both     = 1'b0;
        branch      = 1'b0;
        zero        = 1'b0;
        jump        = 1'b0;
        fill_mem();
        step();
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b expected 0", instr_valid); end
        tests++; if (pc !== 32'h0) begin fails++; $display("FAIL rst_pc: got %h expected 0", pc); end
        tests++; if (instr !== 32'h0) begin fails++; $display("FAIL rst_instr: got %h expected 0", instr); end
        tests++; if (fetch_err !== 1'b0) begin fails++; $display("FAIL rst_err: got %b expected 0", fetch_err); end
        tests++; if (pc_plus4 !== 32'h4) begin fails++; $display("FAIL rst_pc4: got %h expected 4", pc_plus4); end
        mem[0] = 32'h2008_0005;
        mem_en = 1'b1;
        rst    = 1'b0;
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL bubble_req: got %b expected 0", imem_req); end
        step();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            fails++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr);
        end
        step();
        tests++; if (instr_valid !== 1'b1 || instr !== 32'h2008_0005) begin
            fails++; $display("FAIL first_instr: got v=%b %h expected v=1 20080005", instr_valid, instr);
        end
        tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL hold_req: got %b expected 0", imem_req); end
    endtask

    task automatic test_sequential();
        logic [31:0] a;
        exp_t        e;
        int          last_req;
        int          n;
        do_reset();
        fill_mem();
        mem_en      = 1'b1;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_q.push_back(32'(i * 4));
            e.pc = 32'(i * 4);
            e.instr = mem[i];
            acc_q.push_back(e);
        end
        last_req = -1;
        n = 0;
        while ((req_q.size() != 0 || acc_q.size() != 0) && n < 20) begin
            step();
            n++;
            if (imem_req && req_q.size() != 0) begin
                a = req_q.pop_front();
                tests++; if (imem_addr !== a) begin fails++; $display("FAIL seq_addr: got %h expected %h", imem_addr, a); end
                if (last_req >= 0) begin
                    tests++; if (cyc - last_req != 2) begin
                        fails++; $display("FAIL seq_spacing: got %0d expected 2", cyc - last_req);
                    end
                end
                last_req = cyc;
            end
            if (instr_valid && acc_q.size() != 0) begin
                e = acc_q.pop_front();
                tests++; if (pc !== e.pc || instr !== e.instr) begin
                    fails++; $display("FAIL seq_instr: got pc=%h %h expected pc=%h %h", pc, instr, e.pc, e.instr);
                end
            end
        end
        tests++; if (req_q.size() != 0 || acc_q.size() != 0) begin
            fails++; $display("FAIL seq_timeout: got %0d pending expected 0", req_q.size() + acc_q.size());
        end
        instr_ready = 1'b0;
    endtask

    task automatic test_branch();
        logic [31:0] a;
        int          n;
        for (int zc = 0; zc < 2; zc++) begin
            do_reset();
            fill_mem();
            mem[4]      = 32'h1000_FFFC;
            mem_en      = 1'b1;
            instr_ready = 1'b1;
            zero_ctl    = (zc == 1);
            for (int i = 0; i < 5; i++) req_q.push_back(32'(i * 4));
            req_q.push_back(zc == 1 ? 32'h04 : 32'h14);
            n = 0;
            while (req_q.size() != 0 && n < 30) begin
                step();
                n++;
                if (imem_req && req_q.size() != 0) begin
                    a = req_q.pop_front();
                    tests++; if (imem_addr !== a) begin
                        fails++; $display("FAIL branch_addr(z=%0d): got %h expected %h", zc, imem_addr, a);
                    end
                end
            end
            tests++; if (req_q.size() != 0) begin
                fails++; $display("FAIL branch_timeout: got %0d pending expected 0", req_q.size());
            end
        end
        zero_ctl    = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic test_jump();
        logic [31:0] a;
        int          n;
        do_reset();
        fill_mem();
        mem[16]     = {6'h02, 26'h000_0100};
        mem_en      = 1'b1;
        instr_ready = 1'b1;
        jb_both     = 1'b1;
        zero_ctl    = 1'b1;
        for (int i = 0; i <= 16; i++) req_q.push_back(32'(i * 4));
        req_q.push_back(32'h0000_0400);
        n = 0;
        while (req_q.size() != 0 && n < 60) begin
            step();
            n++;
            if (imem_req && req_q.size() != 0) begin
                a = req_q.pop_front();
                tests++; if (imem_addr !== a) begin fails++; $display("FAIL jump_addr: got %h expected %h", imem_addr, a); end
            end
        end
        tests++; if (req_q.size() != 0) begin
            fails++; $display("FAIL jump_timeout: got %0d pending expected 0", req_q.size());
        end
        tests++; if (pc_plus4 !== 32'h0000_0404) begin
            fails++; $display("FAIL jump_pc4: got %h expected 00000404", pc_plus4);
        end
        jb_both     = 1'b0;
        zero_ctl    = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        exp_t e;
        int   n;
        do_reset();
        fill_mem();
        mem[0] = 32'h2001_1111;
        mem[1] = 32'h2002_2222;
        e.pc = 32'h0; e.instr = 32'h2001_1111; acc_q.push_back(e);
        e.pc = 32'h4; e.instr = 32'h2002_2222; acc_q.push_back(e);
        mem_en      = 1'b1;
        instr_ready = 1'b0;
        n = 0;
        while (!instr_valid && n < 6) begin step(); n++; end
        tests++; if (instr_valid !== 1'b1) begin fails++; $display("FAIL bp_first_timeout: got %b expected 1", instr_valid); end
        for (int k = 0; k < 5; k++) begin
            spur_valid = (k % 2 == 1);
            step();
            tests++; if (instr !== acc_q[0].instr || pc !== acc_q[0].pc || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d: got %h pc=%h v=%b req=%b expected %h pc=%h v=1 req=0",
                                  k, instr, pc, instr_valid, imem_req, acc_q[0].instr, acc_q[0].pc);
            end
        end
        spur_valid  = 1'b0;
        e = acc_q.pop_front();
        tests++; if (instr !== e.instr || pc !== e.pc) begin
            fails++; $display("FAIL bp_accept: got %h pc=%h expected %h pc=%h", instr, pc, e.instr, e.pc);
        end
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            fails++; $display("FAIL bp_resume: got req=%b addr=%h expected req=1 addr=4", imem_req, imem_addr);
        end
        n = 0;
        while (!instr_valid && n < 6) begin step(); n++; end
        e = acc_q.pop_front();
        tests++; if (instr_valid !== 1'b1 || instr !== e.instr || pc !== e.pc) begin
            fails++; $display("FAIL bp_second: got v=%b %h pc=%h expected v=1 %h pc=%h", instr_valid, instr, pc, e.instr, e.pc);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        step();
        tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL to_req: got %b expected 1", imem_req); end
        for (int e = 1; e <= 4; e++) begin
            step();
            if (e < 4) begin
                tests++; if (fetch_err !== 1'b0 || imem_req !== 1'b1) begin
                    fails++; $display("FAIL to_early%0d: got err=%b req=%b expected err=0 req=1", e, fetch_err, imem_req);
                end
            end else begin
                tests++; if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
                    fails++; $display("FAIL to_flag: got err=%b req=%b expected err=1 req=0", fetch_err, imem_req);
                end
            end
        end
        mem_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            tests++; if (fetch_err !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
                fails++; $display("FAIL to_sticky%0d: got err=%b req=%b v=%b expected 1 0 0", k, fetch_err, imem_req, instr_valid);
            end
        end
        mem_en = 1'b0;
        rst    = 1'b1;
        #1;
        tests++; if (fetch_err !== 1'b0 || pc !== 32'h0) begin
            fails++; $display("FAIL to_reset: got err=%b pc=%h expected err=0 pc=0", fetch_err, pc);
        end
        step();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_backpressure();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
